// File: rtl/oam_dma_controller_pkg.sv
// Shared Game Boy definitions for the OAM DMA block: register address, OAM base,
// state encodings and the echo-RAM source remap helper.
package oam_dma_controller_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StSetup = ST_SETUP,
        StRead  = ST_READ,
        StWrite = ST_WRITE,
        StWait  = ST_WAIT
    } dma_state_e;

    // E0..FF alias C0..DF (echo RAM).
    function automatic logic [7:0] echo_remap(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - 8'h20) : src;
    endfunction

endpackage

// File: rtl/oam_dma_controller_strobe_edge.sv
// Registered rising-edge detect of a multi-clock write strobe; emits a one-clock pulse.
// Reusable by any I/O register controller that triggers on a CPU write.
module oam_dma_controller_strobe_edge (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q, level_d;

    always_comb begin
        level_d = level_i;
    end

    // On reset, arm with the current level so a strobe held through reset never fires.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= level_i;
        end else begin
            level_q <= level_d;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA sequencer: a CPU write to FF46 copies LENGTH bytes from {src,00} to OAM.
// Optional echo-RAM source remap is enabled by defining OAM_DMA_ECHO_REMAP_EN.
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter int unsigned LENGTH          = 160,
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter logic [15:0] DEST_BASE       = OAM_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  Di,
    output logic [7:0]  Do,
    output logic [15:0] A_dma,
    input  logic [7:0]  Di_dma,
    output logic [7:0]  Do_dma,
    output logic        rd_dma_n,
    output logic        wr_dma_n,
    output logic        dma_active
);

    localparam int unsigned CntW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [CntW-1:0] SetupLast = CntW'(CYCLES_PER_BYTE - 1);
    localparam logic [CntW-1:0] WaitLast  = CntW'(CYCLES_PER_BYTE - 3);
    localparam logic [7:0]      LastIdx   = 8'(LENGTH - 1);

    dma_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      index_q, index_d;
    logic [7:0]      src_q, src_d;
    logic            active_q, active_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      do_dma_q, do_dma_d;
    logic            rd_n_q, rd_n_d;
    logic            wr_n_q, wr_n_d;
    logic            start;
    logic            byte_done;
    logic [7:0]      src_eff;

    // The CPU read strobe has no effect: FF46 readback is purely combinational.
    logic unused_rd_n;
    assign unused_rd_n = rd_n;

    oam_dma_controller_strobe_edge u_strobe_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (cs & ~wr_n),
        .pulse_o (start)
    );

    always_comb begin
`ifdef OAM_DMA_ECHO_REMAP_EN
        src_eff = echo_remap(src_q);
`else
        src_eff = src_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        index_d   = index_q;
        src_d     = src_q;
        active_d  = active_q;
        byte_done = 1'b0;

        if (start) begin
            // Also a restart from any busy state: in-flight cycle is abandoned.
            src_d    = Di;
            state_d  = StSetup;
            cnt_d    = '0;
            index_d  = '0;
            active_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: ;
                StSetup: begin
                    if (cnt_q == SetupLast) begin
                        state_d = StRead;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRead: state_d = StWrite;
                StWrite: begin
                    if (CYCLES_PER_BYTE == 2) begin
                        byte_done = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end
                StWait: begin
                    if (cnt_q == WaitLast) begin
                        byte_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (byte_done) begin
                if (index_q == LastIdx) begin
                    state_d  = StIdle;
                    active_d = 1'b0;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = StRead;
                end
            end
        end

        // Bus outputs are registered from the next state so they line up with it.
        rd_n_d = (state_d != StRead);
        wr_n_d = (state_d != StWrite);
        addr_d = addr_q;
        if (state_d == StRead) begin
            addr_d = {src_eff, index_d};
        end else if (state_d == StWrite) begin
            addr_d = DEST_BASE + {8'h00, index_d};
        end
        do_dma_d = (state_q == StRead) ? Di_dma : do_dma_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            index_q  <= '0;
            src_q    <= 8'hFF;
            active_q <= 1'b0;
            addr_q   <= '0;
            do_dma_q <= '0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            src_q    <= src_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            do_dma_q <= do_dma_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
        end
    end

    assign Do         = src_q;
    assign A_dma      = addr_q;
    assign Do_dma     = do_dma_q;
    assign rd_dma_n   = rd_n_q;
    assign wr_dma_n   = wr_n_q;
    assign dma_active = active_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: directed vector table, reset corner cases,
// and randomized transfers/restarts/resets scored against a timing-level reference model.
module tb_oam_dma_controller;

    localparam int unsigned LEN  = 160;
    localparam int unsigned CPB  = 4;
    localparam logic [15:0] DEST = 16'hFE00;
    localparam int          NEVER = 32'h3FFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cs    = 1'b0;
    logic        rd_n  = 1'b1;
    logic        wr_n  = 1'b1;
    logic [7:0]  Di    = 8'h00;
    logic [7:0]  Do;
    logic [15:0] A_dma;
    logic [7:0]  Di_dma;
    logic [7:0]  Do_dma;
    logic        rd_dma_n;
    logic        wr_dma_n;
    logic        dma_active;

    logic [7:0] mem [0:65535];
    assign Di_dma = mem[A_dma];

    oam_dma_controller #(
        .LENGTH          (LEN),
        .CYCLES_PER_BYTE (CPB),
        .DEST_BASE       (DEST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cs         (cs),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .Di         (Di),
        .Do         (Do),
        .A_dma      (A_dma),
        .Di_dma     (Di_dma),
        .Do_dma     (Do_dma),
        .rd_dma_n   (rd_dma_n),
        .wr_dma_n   (wr_dma_n),
        .dma_active (dma_active)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t exp_rd[$];
    ev_t exp_wr[$];
    int  act_cnt   = 0;
    int  act_first = -1;
    int  act_last  = -1;
    int  n_chk     = 0;
    int  n_pass    = 0;

    // Bus observer, sampled mid-cycle.
    always @(negedge clock) begin
        ev_t e;
        if (!rd_dma_n) begin
            e.cyc = cyc; e.addr = A_dma; e.data = 8'h00;
            rd_q.push_back(e);
        end
        if (!wr_dma_n) begin
            e.cyc = cyc; e.addr = A_dma; e.data = Do_dma;
            wr_q.push_back(e);
        end
        if (dma_active) begin
            act_cnt++;
            if (act_first < 0) act_first = cyc;
            act_last = cyc;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] eff(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_REMAP_EN
        if (s >= 8'hE0) return s - 8'h20;
`endif
        return s;
    endfunction

    // Byte i of a transfer starting at cycle t0: READ at t0+CPB+1+CPB*i, WRITE one cycle later.
    task automatic add_xfer(input int t0, input logic [7:0] s, input int stop);
        ev_t e;
        for (int i = 0; i < int'(LEN); i++) begin
            int rc;
            rc = t0 + int'(CPB) + 1 + int'(CPB) * i;
            if (rc <= stop) begin
                e.cyc = rc; e.addr = {eff(s), 8'(i)}; e.data = 8'h00;
                exp_rd.push_back(e);
            end
            if (rc + 1 <= stop) begin
                e.cyc = rc + 1; e.addr = DEST + 16'(i); e.data = mem[{eff(s), 8'(i)}];
                exp_wr.push_back(e);
            end
        end
    endtask

    function automatic int first_diff(input ev_t a[$], input ev_t b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) begin
            if (a[i].cyc != b[i].cyc || a[i].addr !== b[i].addr || a[i].data !== b[i].data)
                return i;
        end
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    task automatic run_scn(input logic [7:0] s1, input int rs, input logic [7:0] s2,
                           input int rst, output int t0);
        int stop_at;
        rd_q.delete();
        wr_q.delete();
        act_cnt = 0; act_first = -1; act_last = -1;
        tick();
        t0 = cyc;
        cs = 1'b1; wr_n = 1'b0; Di = s1;
        repeat (4) tick();
        cs = 1'b0; wr_n = 1'b1;
        stop_at = t0 + rs + int'(CPB * (LEN + 1)) + 10;
        while (cyc < stop_at) begin
            rd_n = 1'($urandom_range(0, 1));
            if (rs != 0 && cyc == t0 + rs) begin
                cs = 1'b1; wr_n = 1'b0; Di = s2;
            end
            if (rs != 0 && cyc == t0 + rs + 2) begin
                cs = 1'b0; wr_n = 1'b1;
            end
            if (rst != 0 && cyc == t0 + rst) reset = 1'b1;
            if (rst != 0 && cyc == t0 + rst + 1) begin
                reset = 1'b0;
                check("post_reset_active", int'(dma_active), 0);
                check("post_reset_rd_n", int'(rd_dma_n), 1);
                check("post_reset_wr_n", int'(wr_dma_n), 1);
                check("post_reset_Do", int'(Do), 'hFF);
            end
            tick();
        end
        rd_n = 1'b1;
    endtask

    task automatic check_model(input int t0, input logic [7:0] s1, input int rs,
                               input logic [7:0] s2, input int rst);
        int lim1, lim2, last_start, act_end, d;
        exp_rd.delete();
        exp_wr.delete();
        lim2 = (rst != 0) ? t0 + rst : NEVER;
        lim1 = (rs != 0) ? t0 + rs : lim2;
        add_xfer(t0, s1, lim1);
        if (rs != 0) add_xfer(t0 + rs, s2, lim2);
        d = first_diff(rd_q, exp_rd);
        check($sformatf("rd_stream first_diff_idx (nrd=%0d)", rd_q.size()), d, -1);
        d = first_diff(wr_q, exp_wr);
        check($sformatf("wr_stream first_diff_idx (nwr=%0d)", wr_q.size()), d, -1);
        last_start = t0 + rs;
        act_end = last_start + int'(CPB * (LEN + 1));
        if (rst != 0 && t0 + rst < act_end) act_end = t0 + rst;
        check("active_first", act_first - t0, 1);
        check("active_last", act_last - t0, act_end - t0);
        check("active_count", act_cnt, act_end - t0);
        check("Do_after", int'(Do), (rst != 0) ? 'hFF : int'((rs != 0) ? s2 : s1));
    endtask

    typedef struct {
        logic [7:0]  src;
        int          rs_at;
        logic [7:0]  src2;
        int          rst_at;
        int          exp_rd_off;
        logic [15:0] exp_rd_addr;
        int          exp_wr_off;
        logic [15:0] exp_wr_addr;
        int          exp_act;
        int          exp_nrd;
        logic [7:0]  exp_do;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0;
        logic [15:0] e2_addr;
`ifdef OAM_DMA_ECHO_REMAP_EN
        e2_addr = 16'hC200;
`else
        e2_addr = 16'hE200;
`endif
        vecs[0] = '{8'hC1, 0,   8'h00, 0,   5,   16'hC100, 642, 16'hFE9F, 644, 160, 8'hC1};
        vecs[1] = '{8'hC1, 100, 8'hD0, 0,   105, 16'hD000, 742, 16'hFE9F, 744, 184, 8'hD0};
        vecs[2] = '{8'hC1, 0,   8'h00, 300, 5,   16'hC100, 298, 16'hFE49, 300, 74,  8'hFF};
        vecs[3] = '{8'hE2, 0,   8'h00, 0,   5,   e2_addr,  642, 16'hFE9F, 644, 160, 8'hE2};
        vecs[4] = '{8'hC0, 8,   8'hDF, 0,   13,  16'hDF00, 650, 16'hFE9F, 652, 161, 8'hDF};

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'hC100 + 16'(i)] = 8'(i);

        // Reset values, sampled while reset is still held.
        repeat (3) tick();
        check("reset_Do", int'(Do), 'hFF);
        check("reset_A_dma", int'(A_dma), 0);
        check("reset_Do_dma", int'(Do_dma), 0);
        check("reset_rd_dma_n", int'(rd_dma_n), 1);
        check("reset_wr_dma_n", int'(wr_dma_n), 1);
        check("reset_active", int'(dma_active), 0);
        reset = 1'b0;
        tick();

        // A write strobe on the reset clock must not start a transfer.
        reset = 1'b1; cs = 1'b1; wr_n = 1'b0; Di = 8'hC5;
        tick();
        reset = 1'b0; cs = 1'b0; wr_n = 1'b1;
        rd_q.delete();
        act_cnt = 0;
        repeat (20) tick();
        check("reset_clock_start_active", act_cnt, 0);
        check("reset_clock_start_reads", rd_q.size(), 0);
        check("reset_clock_start_Do", int'(Do), 'hFF);

        for (int v = 0; v < 5; v++) begin
            int k;
            run_scn(vecs[v].src, vecs[v].rs_at, vecs[v].src2, vecs[v].rst_at, t0);
            k = -1;
            for (int i = 0; i < rd_q.size(); i++) begin
                if (k < 0 && rd_q[i].cyc >= t0 + vecs[v].rs_at) k = i;
            end
            check($sformatf("v%0d first_read_off", v), (k < 0) ? -1 : rd_q[k].cyc - t0,
                  vecs[v].exp_rd_off);
            check($sformatf("v%0d first_read_addr", v), (k < 0) ? -1 : int'(rd_q[k].addr),
                  int'(vecs[v].exp_rd_addr));
            check($sformatf("v%0d last_write_off", v),
                  (wr_q.size() == 0) ? -1 : wr_q[wr_q.size() - 1].cyc - t0, vecs[v].exp_wr_off);
            check($sformatf("v%0d last_write_addr", v),
                  (wr_q.size() == 0) ? -1 : int'(wr_q[wr_q.size() - 1].addr),
                  int'(vecs[v].exp_wr_addr));
            check($sformatf("v%0d active_cycles", v), act_cnt, vecs[v].exp_act);
            check($sformatf("v%0d read_count", v), rd_q.size(), vecs[v].exp_nrd);
            check($sformatf("v%0d write_count", v), wr_q.size(), vecs[v].exp_nrd);
            check($sformatf("v%0d Do", v), int'(Do), int'(vecs[v].exp_do));
            check_model(t0, vecs[v].src, vecs[v].rs_at, vecs[v].src2, vecs[v].rst_at);
        end

        for (int n = 0; n < 8; n++) begin
            logic [7:0] s1, s2;
            int mode, rs, rst;
            s1 = 8'($urandom);
            s2 = 8'($urandom);
            mode = $urandom_range(0, 2);
            rs = (mode == 1) ? $urandom_range(8, 600) : 0;
            rst = (mode == 2) ? $urandom_range(8, 640) : 0;
            run_scn(s1, rs, s2, rst, t0);
            check_model(t0, s1, rs, s2, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
